// File: rtl/rv32i_pkg.sv
// rv32i_pkg: RV32I major opcodes and immediate format selector shared by decode logic
package rv32i_pkg;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} imm_type_e;
endpackage

// File: rtl/imm_gen.sv
// imm_gen: sign-extended immediate for the selected RV32I instruction format
module imm_gen
  import rv32i_pkg::*;
(
  input  logic [31:7] instr,
  input  imm_type_e   imm_type,
  output logic [31:0] imm
);
  always_comb begin
    imm = imm_type == IMM_I ? {{20{instr[31]}}, instr[31:20]} :
          imm_type == IMM_S ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
          imm_type == IMM_B ? {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} :
          imm_type == IMM_U ? {instr[31:12], 12'b0} :
          imm_type == IMM_J ? {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} :
          32'b0;
  end
endmodule

// File: rtl/id_stage.sv
// id_stage: RV32I decode stage with writeback bypass, load-use stall and ID/EX register
module id_stage
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  input  logic            flush,
  output logic [4:0]      rf_raddr1,
  output logic [4:0]      rf_raddr2,
  input  logic [31:0]     rf_rdata1,
  input  logic [31:0]     rf_rdata2,
  input  logic            wb_reg_write,
  input  logic [4:0]      wb_waddr,
  input  logic [31:0]     wb_wdata,
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [6:0]      ex_opcode,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7b5,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic            ex_reg_write,
  output logic            ex_is_load,
  output logic [31:0]     ex_rs1_val,
  output logic [31:0]     ex_rs2_val,
  output logic [31:0]     ex_imm,
  output logic            ex_illegal
);
  logic [6:0] opcode;
  logic legal, uses_rs1, uses_rs2, has_rd, is_load;
  imm_type_e imm_type;
  logic [4:0] rs1, rs2, rd;
  logic [31:0] imm, rs1_val, rs2_val;
  logic load_use, advance, accept;
  assign opcode = if_instr[6:0];
  always_comb begin
    legal = 1'b1;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    has_rd = 1'b0;
    is_load = 1'b0;
    imm_type = IMM_NONE;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin has_rd = 1'b1; imm_type = IMM_U; end
      OPC_JAL:     begin has_rd = 1'b1; imm_type = IMM_J; end
      OPC_JALR:    begin has_rd = 1'b1; uses_rs1 = 1'b1; imm_type = IMM_I; end
      OPC_BRANCH:  begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; imm_type = IMM_B; end
      OPC_LOAD:    begin has_rd = 1'b1; uses_rs1 = 1'b1; is_load = 1'b1; imm_type = IMM_I; end
      OPC_STORE:   begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; imm_type = IMM_S; end
      OPC_OPIMM:   begin has_rd = 1'b1; uses_rs1 = 1'b1; imm_type = IMM_I; end
      OPC_OP:      begin has_rd = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      OPC_MISCMEM: imm_type = IMM_NONE;
      OPC_SYSTEM:  imm_type = IMM_I;
      default:     legal = 1'b0;
    endcase
  end
  imm_gen u_imm_gen (.instr(if_instr[31:7]), .imm_type(imm_type), .imm(imm));
  assign rf_raddr1 = if_instr[19:15];
  assign rf_raddr2 = if_instr[24:20];
  assign rs1 = uses_rs1 ? if_instr[19:15] : 5'd0;
  assign rs2 = uses_rs2 ? if_instr[24:20] : 5'd0;
  assign rd  = has_rd ? if_instr[11:7] : 5'd0;
  // The register file does not forward its own write port, so catch same-cycle writebacks here
  assign rs1_val = !uses_rs1 ? 32'd0 : (wb_reg_write && wb_waddr != 5'd0 && wb_waddr == rs1) ? wb_wdata : rf_rdata1;
  assign rs2_val = !uses_rs2 ? 32'd0 : (wb_reg_write && wb_waddr != 5'd0 && wb_waddr == rs2) ? wb_wdata : rf_rdata2;
  assign load_use = ex_valid & ex_is_load & (ex_rd != 5'd0) & if_valid &
                    ((uses_rs1 & (rs1 == ex_rd)) | (uses_rs2 & (rs2 == ex_rd)));
  assign advance  = !ex_valid | ex_ready;
  assign if_ready = flush | (advance & !load_use);
  assign accept   = !flush & advance & !load_use & if_valid;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid     <= 1'b0;
      ex_pc        <= RESET_PC;
      ex_opcode    <= '0;
      ex_funct3    <= '0;
      ex_funct7b5  <= 1'b0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rd        <= '0;
      ex_reg_write <= 1'b0;
      ex_is_load   <= 1'b0;
      ex_rs1_val   <= '0;
      ex_rs2_val   <= '0;
      ex_imm       <= '0;
      ex_illegal   <= 1'b0;
    end else begin
      if (flush || advance) ex_valid <= accept;
      if (accept) begin
        ex_pc        <= if_pc;
        ex_opcode    <= opcode;
        ex_funct3    <= if_instr[14:12];
        ex_funct7b5  <= if_instr[30];
        ex_rs1       <= rs1;
        ex_rs2       <= rs2;
        ex_rd        <= rd;
        ex_reg_write <= rd != 5'd0;
        ex_is_load   <= is_load;
        ex_rs1_val   <= rs1_val;
        ex_rs2_val   <= rs2_val;
        ex_imm       <= imm;
        ex_illegal   <= !legal;
      end
    end
  end
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed vector table plus hand-written hazard, stall, flush and reset sequences
module tb_id_stage;
  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] I_ADDI_M1 = 32'hFFF00293;
  localparam logic [31:0] I_LW      = 32'h0000A303;
  localparam logic [31:0] I_ADD_DEP = 32'h002303B3;
  localparam logic [31:0] I_ADD_IND = 32'h003103B3;
  logic clk = 1'b0, reset_n = 1'b0;
  logic if_valid = 1'b0, if_ready, flush = 1'b0;
  logic [31:0] if_instr = '0, if_pc = '0;
  logic [4:0] rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1 = '0, rf_rdata2 = '0;
  logic wb_reg_write = 1'b0;
  logic [4:0] wb_waddr = '0;
  logic [31:0] wb_wdata = '0;
  logic ex_ready = 1'b1, ex_valid;
  logic [31:0] ex_pc;
  logic [6:0] ex_opcode;
  logic [2:0] ex_funct3;
  logic ex_funct7b5;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic ex_reg_write, ex_is_load, ex_illegal;
  logic [31:0] ex_rs1_val, ex_rs2_val, ex_imm;
  int total = 0, bad = 0;

  id_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .reset_n(reset_n), .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc), .flush(flush),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .wb_reg_write(wb_reg_write), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_opcode(ex_opcode),
    .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
    .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm), .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr, rd1, rd2;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  e_rd, e_rs1, e_rs2;
    logic [31:0] e_imm, e_v1, e_v2;
    logic        e_ill, e_ld, e_rw;
  } vec_t;
  vec_t v[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic valid, input logic [31:0] instr, input logic [31:0] pc);
    if_valid = valid;
    if_instr = instr;
    if_pc = pc;
  endtask

  initial begin
    v[0]  = '{I_ADDI_M1,    32'h0,    32'h99, 1'b0, 5'd0, 32'h0,  5'd5,  5'd0, 5'd0, 32'hFFFFFFFF, 32'h0,    32'h0,  1'b0, 1'b0, 1'b1};
    v[1]  = '{I_LW,         32'h1000, 32'h99, 1'b0, 5'd0, 32'h0,  5'd6,  5'd1, 5'd0, 32'h0,        32'h1000, 32'h0,  1'b0, 1'b1, 1'b1};
    v[2]  = '{I_ADD_DEP,    32'h11,   32'h22, 1'b0, 5'd0, 32'h0,  5'd7,  5'd6, 5'd2, 32'h0,        32'h11,   32'h22, 1'b0, 1'b0, 1'b1};
    v[3]  = '{32'h00508193, 32'h11,   32'h0,  1'b1, 5'd1, 32'hAB, 5'd3,  5'd1, 5'd0, 32'h5,        32'hAB,   32'h0,  1'b0, 1'b0, 1'b1};
    v[4]  = '{32'h00508193, 32'h11,   32'h0,  1'b1, 5'd0, 32'hAB, 5'd3,  5'd1, 5'd0, 32'h5,        32'h11,   32'h0,  1'b0, 1'b0, 1'b1};
    v[5]  = '{32'h0020A423, 32'h40,   32'h55, 1'b1, 5'd2, 32'h77, 5'd0,  5'd1, 5'd2, 32'h8,        32'h40,   32'h77, 1'b0, 1'b0, 1'b0};
    v[6]  = '{32'hFE208EE3, 32'h1,    32'h2,  1'b0, 5'd0, 32'h0,  5'd0,  5'd1, 5'd2, 32'hFFFFFFFC, 32'h1,    32'h2,  1'b0, 1'b0, 1'b0};
    v[7]  = '{32'h12345537, 32'h33,   32'h44, 1'b1, 5'd8, 32'hEE, 5'd10, 5'd0, 5'd0, 32'h12345000, 32'h0,    32'h0,  1'b0, 1'b0, 1'b1};
    v[8]  = '{32'h001000EF, 32'h5,    32'h6,  1'b0, 5'd0, 32'h0,  5'd1,  5'd0, 5'd0, 32'h800,      32'h0,    32'h0,  1'b0, 1'b0, 1'b1};
    v[9]  = '{32'h00000073, 32'h0,    32'h0,  1'b0, 5'd0, 32'h0,  5'd0,  5'd0, 5'd0, 32'h0,        32'h0,    32'h0,  1'b0, 1'b0, 1'b0};
    v[10] = '{32'h00000000, 32'h0,    32'h0,  1'b0, 5'd0, 32'h0,  5'd0,  5'd0, 5'd0, 32'h0,        32'h0,    32'h0,  1'b1, 1'b0, 1'b0};
    v[11] = '{32'h0FF0008F, 32'h0,    32'h0,  1'b0, 5'd0, 32'h0,  5'd0,  5'd0, 5'd0, 32'h0,        32'h0,    32'h0,  1'b0, 1'b0, 1'b0};
    v[12] = '{32'h00500290, 32'h0,    32'h0,  1'b0, 5'd0, 32'h0,  5'd0,  5'd0, 5'd0, 32'h0,        32'h0,    32'h0,  1'b1, 1'b0, 1'b0};

    #12;
    chk("rst_valid", {31'b0, ex_valid}, 32'h0);
    chk("rst_pc", ex_pc, RST_PC);
    chk("rst_rd", {27'b0, ex_rd}, 32'h0);
    chk("rst_imm", ex_imm, 32'h0);
    chk("rst_if_ready", {31'b0, if_ready}, 32'h1);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 13; i++) begin
      logic [31:0] ins;
      ins = v[i].instr;
      drive(1'b1, ins, 32'h100 + 32'(i * 4));
      rf_rdata1 = v[i].rd1;
      rf_rdata2 = v[i].rd2;
      wb_reg_write = v[i].we;
      wb_waddr = v[i].wa;
      wb_wdata = v[i].wd;
      #1;
      chk($sformatf("v%0d_raddr1", i), {27'b0, rf_raddr1}, {27'b0, ins[19:15]});
      chk($sformatf("v%0d_if_ready", i), {31'b0, if_ready}, 32'h1);
      tick();
      drive(1'b0, 32'h0, 32'h0);
      wb_reg_write = 1'b0;
      chk($sformatf("v%0d_valid", i), {31'b0, ex_valid}, 32'h1);
      chk($sformatf("v%0d_pc", i), ex_pc, 32'h100 + 32'(i * 4));
      chk($sformatf("v%0d_opcode", i), {25'b0, ex_opcode}, {25'b0, ins[6:0]});
      chk($sformatf("v%0d_rd", i), {27'b0, ex_rd}, {27'b0, v[i].e_rd});
      chk($sformatf("v%0d_rs1", i), {27'b0, ex_rs1}, {27'b0, v[i].e_rs1});
      chk($sformatf("v%0d_rs2", i), {27'b0, ex_rs2}, {27'b0, v[i].e_rs2});
      chk($sformatf("v%0d_imm", i), ex_imm, v[i].e_imm);
      chk($sformatf("v%0d_rs1_val", i), ex_rs1_val, v[i].e_v1);
      chk($sformatf("v%0d_rs2_val", i), ex_rs2_val, v[i].e_v2);
      chk($sformatf("v%0d_illegal", i), {31'b0, ex_illegal}, {31'b0, v[i].e_ill});
      chk($sformatf("v%0d_is_load", i), {31'b0, ex_is_load}, {31'b0, v[i].e_ld});
      chk($sformatf("v%0d_reg_write", i), {31'b0, ex_reg_write}, {31'b0, v[i].e_rw});
      tick();
    end

    // load-use: one bubble, then the dependent ADD
    drive(1'b1, I_LW, 32'h200);
    tick();
    drive(1'b1, I_ADD_DEP, 32'h204);
    #1;
    chk("lu_if_ready_low", {31'b0, if_ready}, 32'h0);
    tick();
    chk("lu_bubble", {31'b0, ex_valid}, 32'h0);
    chk("lu_if_ready_back", {31'b0, if_ready}, 32'h1);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("lu_add_valid", {31'b0, ex_valid}, 32'h1);
    chk("lu_add_rs1", {27'b0, ex_rs1}, 32'd6);
    chk("lu_add_pc", ex_pc, 32'h204);
    tick();

    // independent instruction after a load: no bubble
    drive(1'b1, I_LW, 32'h300);
    tick();
    drive(1'b1, I_ADD_IND, 32'h304);
    #1;
    chk("nolu_if_ready", {31'b0, if_ready}, 32'h1);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("nolu_valid", {31'b0, ex_valid}, 32'h1);
    chk("nolu_rd", {27'b0, ex_rd}, 32'd7);
    tick();

    // backpressure for three cycles
    drive(1'b1, I_ADDI_M1, 32'h400);
    tick();
    ex_ready = 1'b0;
    drive(1'b1, I_ADD_IND, 32'h404);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp%0d_if_ready", c), {31'b0, if_ready}, 32'h0);
      chk($sformatf("bp%0d_rd", c), {27'b0, ex_rd}, 32'd5);
      chk($sformatf("bp%0d_imm", c), ex_imm, 32'hFFFFFFFF);
      chk($sformatf("bp%0d_pc", c), ex_pc, 32'h400);
      tick();
    end
    ex_ready = 1'b1;
    #1;
    chk("bp_release_if_ready", {31'b0, if_ready}, 32'h1);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("bp_captured_rd", {27'b0, ex_rd}, 32'd7);
    chk("bp_captured_pc", ex_pc, 32'h404);
    tick();

    // flush over a pending load-use
    drive(1'b1, I_LW, 32'h500);
    tick();
    drive(1'b1, I_ADD_DEP, 32'h504);
    flush = 1'b1;
    #1;
    chk("fl_if_ready", {31'b0, if_ready}, 32'h1);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    chk("fl_valid", {31'b0, ex_valid}, 32'h0);
    tick();
    chk("fl_dropped", {31'b0, ex_valid}, 32'h0);
    chk("fl_pc_kept", ex_pc, 32'h500);

    // all-zero word is illegal, then asynchronous reset mid-stream
    drive(1'b1, 32'h0, 32'h600);
    tick();
    chk("z_valid", {31'b0, ex_valid}, 32'h1);
    chk("z_illegal", {31'b0, ex_illegal}, 32'h1);
    chk("z_reg_write", {31'b0, ex_reg_write}, 32'h0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", {31'b0, ex_valid}, 32'h0);
    chk("arst_pc", ex_pc, RST_PC);
    chk("arst_illegal", {31'b0, ex_illegal}, 32'h0);
    tick();
    reset_n = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    tick();
    chk("post_rst_valid", {31'b0, ex_valid}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
